ni_packetizer: RTL

//  Network-interface transmit stage feeding a router Local input port (L_RX/L_DRTS/L_CTS).

---
 rtl/ni_packetizer_if.sv | 23 ++
 rtl/ni_packetizer.sv | 103 ++++++++++
 2 files changed

// File: rtl/ni_packetizer_if.sv
// Local-port bundle between the core/router side (master) and the packetizer (slave).
interface ni_packetizer_if;
  logic        cmd_valid;
  logic [3:0]  cmd_dst;
  logic [11:0] cmd_len;
  logic        cmd_ready;
  logic        pl_valid;
  logic [27:0] pl_data;
  logic        pl_ready;
  logic [31:0] TX;
  logic        RTS;
  logic        DCTS;

  modport master (
    output cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, DCTS,
    input  cmd_ready, pl_ready, TX, RTS
  );

  modport slave (
    input  cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, DCTS,
    output cmd_ready, pl_ready, TX, RTS
  );
endinterface

// File: rtl/ni_packetizer.sv
// NI transmit stage: turns a packet command plus payload words into Header/Body/Tail
// flits with even parity, paced by the router's RTS/CTS handshake.
module ni_packetizer #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  CUR_ADDR   = 4'b0000,
  parameter logic [11:0] MAX_LEN    = 12'd64
) (
  input  logic              clk,
  input  logic              rst,
  ni_packetizer_if.slave    bus,
  output logic              busy,
  output logic              pkt_sent,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  localparam logic [2:0] T_HDR  = 3'b001;
  localparam logic [2:0] T_BODY = 3'b010;
  localparam logic [2:0] T_TAIL = 3'b100;

  state_t      state;
  logic [11:0] len_q;
  logic [11:0] rem;
  logic [3:0]  dst_q;
  logic [7:0]  seq;
  logic        len_ok;

  function automatic logic [DATA_WIDTH-1:0] mk_flit(input logic [2:0] t, input logic [27:0] f);
    mk_flit = {t, f, ^{t, f}};
  endfunction

  assign len_ok       = (bus.cmd_len >= 12'd2) && (bus.cmd_len <= MAX_LEN);
  assign busy         = (state != IDLE);
  // Consumption must coincide with a launch edge, so pl_ready follows DCTS directly.
  assign bus.pl_ready = (state == PAY) && bus.DCTS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.TX        <= '0;
      bus.RTS       <= 1'b0;
      bus.cmd_ready <= 1'b0;
      pkt_sent      <= 1'b0;
      len_err       <= 1'b0;
      seq           <= '0;
      len_q         <= '0;
      dst_q         <= '0;
      rem           <= '0;
    end else begin
      bus.RTS  <= 1'b0;
      pkt_sent <= 1'b0;
      len_err  <= 1'b0;
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            if (len_ok) begin
              len_q         <= bus.cmd_len;
              dst_q         <= bus.cmd_dst;
              rem           <= bus.cmd_len - 12'd1;
              bus.cmd_ready <= 1'b0;
              state         <= HDR;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (bus.DCTS) begin
            bus.TX  <= mk_flit(T_HDR, {len_q, dst_q, CUR_ADDR, seq});
            bus.RTS <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (rem != 12'd0) begin
            state <= PAY;
          end else begin
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        PAY: begin
          if (bus.pl_valid && bus.DCTS) begin
            bus.RTS <= 1'b1;
            rem     <= rem - 12'd1;
            state   <= GAP;
            if (rem == 12'd1) begin
              bus.TX   <= mk_flit(T_TAIL, bus.pl_data);
              pkt_sent <= 1'b1;
              seq      <= seq + 8'd1;
            end else begin
              bus.TX <= mk_flit(T_BODY, bus.pl_data);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
